// File: rtl/gpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gpu_pkg
// Description : Shared definitions for the GPU line rasteriser. Holds the
//               default geometry/colour/stipple widths and the line FSM
//               state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package gpu_pkg;

    localparam int c_WIDTH_BITS   = 10;
    localparam int c_HEIGHT_BITS  = 9;
    localparam int c_CHANNEL_BITS = 8;
    localparam int c_PAT_BITS     = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DRAW = 2'd1,
        ST_DONE = 2'd2
    } line_state_t;

endpackage
`default_nettype wire

// File: rtl/gpu_line_raster.sv
`default_nettype none
// ============================================================================
// Module      : gpu_line_raster
// Description : Bresenham line rasteriser with valid/ready command and pixel
//               interfaces, optional stipple masking and abort.
// Revision    : 1.0 - initial release
//
// Ports
//   clk, n_rst            clock, synchronous active-low reset
//   cmd_valid/cmd_ready   command handshake (ready only while idle)
//   x1,y1,x2,y2           line endpoints
//   r_i,g_i,b_i           line colour
//   stipple_en, pattern   stipple mask, bit 0 applies to the first pixel
//   abort                 cancels the line being drawn
//   px_valid/px_ready     pixel handshake
//   X, Y                  current pixel coordinate
//   r_o,g_o,b_o           colour latched at command acceptance
//   busy                  line in progress
//   done                  one-cycle completion pulse
// ============================================================================
module gpu_line_raster
    import gpu_pkg::*;
#(
    parameter int WIDTH_BITS   = c_WIDTH_BITS,
    parameter int HEIGHT_BITS  = c_HEIGHT_BITS,
    parameter int CHANNEL_BITS = c_CHANNEL_BITS,
    parameter int PAT_BITS     = c_PAT_BITS
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [WIDTH_BITS-1:0]   x1,
    input  logic [WIDTH_BITS-1:0]   x2,
    input  logic [HEIGHT_BITS-1:0]  y1,
    input  logic [HEIGHT_BITS-1:0]  y2,
    input  logic [CHANNEL_BITS-1:0] r_i,
    input  logic [CHANNEL_BITS-1:0] g_i,
    input  logic [CHANNEL_BITS-1:0] b_i,
    input  logic                    stipple_en,
    input  logic [PAT_BITS-1:0]     pattern,
    input  logic                    abort,
    output logic                    px_valid,
    input  logic                    px_ready,
    output logic [WIDTH_BITS-1:0]   X,
    output logic [HEIGHT_BITS-1:0]  Y,
    output logic [CHANNEL_BITS-1:0] r_o,
    output logic [CHANNEL_BITS-1:0] g_o,
    output logic [CHANNEL_BITS-1:0] b_o,
    output logic                    busy,
    output logic                    done
);

    // Two guard bits over the wider axis: one for sign, one so e2 = 2*err
    // never overflows for any legal endpoint pair.
    localparam int c_CW   = ((WIDTH_BITS > HEIGHT_BITS) ? WIDTH_BITS : HEIGHT_BITS) + 2;
    localparam int c_IDXW = (PAT_BITS > 1) ? $clog2(PAT_BITS) : 1;

    line_state_t r_state;
    line_state_t w_state_next;

    logic [WIDTH_BITS-1:0]   r_x2;
    logic [HEIGHT_BITS-1:0]  r_y2;
    logic signed [c_CW-1:0]  r_dx;
    logic signed [c_CW-1:0]  r_dy;
    logic signed [c_CW-1:0]  r_err;
    logic                    r_sx_neg;
    logic                    r_sy_neg;
    logic                    r_stipple;
    logic [PAT_BITS-1:0]     r_pattern;
    logic [c_IDXW-1:0]       r_idx;

    logic signed [c_CW-1:0]  w_x1;
    logic signed [c_CW-1:0]  w_x2;
    logic signed [c_CW-1:0]  w_y1;
    logic signed [c_CW-1:0]  w_y2;
    logic signed [c_CW-1:0]  w_dx_abs;
    logic signed [c_CW-1:0]  w_dy_neg;
    logic signed [c_CW-1:0]  w_e2;
    logic signed [c_CW-1:0]  w_err_next;
    logic                    w_in_draw;
    logic                    w_accept;
    logic                    w_masked;
    logic                    w_consume;
    logic                    w_final;
    logic                    w_step_x;
    logic                    w_step_y;

    // Endpoints zero-extended into the signed error domain.
    assign w_x1 = $signed(c_CW'(x1));
    assign w_x2 = $signed(c_CW'(x2));
    assign w_y1 = $signed(c_CW'(y1));
    assign w_y2 = $signed(c_CW'(y2));

    assign w_dx_abs = (w_x1 < w_x2) ? (w_x2 - w_x1) : (w_x1 - w_x2);
    assign w_dy_neg = (w_y1 < w_y2) ? (w_y1 - w_y2) : (w_y2 - w_y1);

    assign w_in_draw = (r_state == ST_DRAW);
    assign w_accept  = cmd_valid && (r_state == ST_IDLE);
    assign w_masked  = r_stipple && !r_pattern[r_idx];
    // A masked pixel is skipped without waiting on the sink.
    assign w_consume = w_in_draw && (w_masked || px_ready);
    assign w_final   = (X == r_x2) && (Y == r_y2);

    assign w_e2       = r_err <<< 1;
    assign w_step_x   = (w_e2 >= r_dy);
    assign w_step_y   = (w_e2 <= r_dx);
    assign w_err_next = r_err + (w_step_x ? r_dy : '0) + (w_step_y ? r_dx : '0);

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        cmd_ready    = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        px_valid     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    w_state_next = ST_DRAW;
                end
            end
            ST_DRAW: begin
                busy     = 1'b1;
                px_valid = !w_masked;
                // Abort wins even over a final-pixel handshake: no done pulse.
                if (abort) begin
                    w_state_next = ST_IDLE;
                end else if (w_consume && w_final) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done         = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            X         <= '0;
            Y         <= '0;
            r_o       <= '0;
            g_o       <= '0;
            b_o       <= '0;
            r_x2      <= '0;
            r_y2      <= '0;
            r_dx      <= '0;
            r_dy      <= '0;
            r_err     <= '0;
            r_sx_neg  <= 1'b0;
            r_sy_neg  <= 1'b0;
            r_stipple <= 1'b0;
            r_pattern <= '0;
            r_idx     <= '0;
        end else if (w_accept) begin
            X         <= x1;
            Y         <= y1;
            r_o       <= r_i;
            g_o       <= g_i;
            b_o       <= b_i;
            r_x2      <= x2;
            r_y2      <= y2;
            r_dx      <= w_dx_abs;
            r_dy      <= w_dy_neg;
            r_err     <= w_dx_abs + w_dy_neg;
            r_sx_neg  <= !(x1 < x2);
            r_sy_neg  <= !(y1 < y2);
            r_stipple <= stipple_en;
            r_pattern <= pattern;
            r_idx     <= '0;
        end else if (w_consume && !w_final && !abort) begin
            r_err <= w_err_next;
            if (w_step_x) begin
                X <= r_sx_neg ? (X - WIDTH_BITS'(1)) : (X + WIDTH_BITS'(1));
            end
            if (w_step_y) begin
                Y <= r_sy_neg ? (Y - HEIGHT_BITS'(1)) : (Y + HEIGHT_BITS'(1));
            end
            r_idx <= (r_idx == c_IDXW'(PAT_BITS - 1)) ? '0 : (r_idx + c_IDXW'(1));
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gpu_line_raster.sv
`default_nettype none
// ============================================================================
// Module      : tb_gpu_line_raster
// Description : Self-checking bench for gpu_line_raster. A behavioural line
//               model produces the expected pixel sequence; directed and
//               random lines are compared pixel by pixel.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gpu_line_raster;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [9:0]  x1, x2;
    logic [8:0]  y1, y2;
    logic [7:0]  r_i, g_i, b_i;
    logic        stipple_en;
    logic [15:0] pattern;
    logic        abort;
    logic        px_valid;
    logic        px_ready;
    logic [9:0]  X;
    logic [8:0]  Y;
    logic [7:0]  r_o, g_o, b_o;
    logic        busy;
    logic        done;

    int vectors     = 0;
    int miscompares = 0;

    int exp_x[$];
    int exp_y[$];

    always #5 clk = ~clk;

    gpu_line_raster dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .x1         (x1),
        .x2         (x2),
        .y1         (y1),
        .y2         (y2),
        .r_i        (r_i),
        .g_i        (g_i),
        .b_i        (b_i),
        .stipple_en (stipple_en),
        .pattern    (pattern),
        .abort      (abort),
        .px_valid   (px_valid),
        .px_ready   (px_ready),
        .X          (X),
        .Y          (Y),
        .r_o        (r_o),
        .g_o        (g_o),
        .b_o        (b_o),
        .busy       (busy),
        .done       (done)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference line: walks the ideal Bresenham path and keeps only the
    // pixels the stipple pattern lets through.
    task automatic build_model(input int ax1, input int ay1, input int ax2, input int ay2,
                               input bit stip, input logic [15:0] pat, output int n_total);
        int dx, dy, sx, sy, err, e2, x, y, k;
        exp_x.delete();
        exp_y.delete();
        dx  = (ax2 > ax1) ? ax2 - ax1 : ax1 - ax2;
        dy  = (ay2 > ay1) ? ay1 - ay2 : ay2 - ay1;
        sx  = (ax1 < ax2) ? 1 : -1;
        sy  = (ay1 < ay2) ? 1 : -1;
        err = dx + dy;
        x   = ax1;
        y   = ay1;
        k   = 0;
        forever begin
            if (!stip || pat[k % 16]) begin
                exp_x.push_back(x);
                exp_y.push_back(y);
            end
            k++;
            if (x == ax2 && y == ay2) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; x += sx; end
            if (e2 <= dx) begin err += dx; y += sy; end
        end
        n_total = k;
    endtask

    // Presents a command for one cycle, then scrambles every command input
    // so any use of unlatched values shows up as a wrong pixel.
    task automatic issue(input int ax1, input int ay1, input int ax2, input int ay2,
                         input bit stip, input logic [15:0] pat, output logic [23:0] col);
        col = 24'($urandom);
        check("cmd_ready_idle", 64'(cmd_ready), 64'(1));
        x1         = 10'(ax1);
        y1         = 9'(ay1);
        x2         = 10'(ax2);
        y2         = 9'(ay2);
        r_i        = col[23:16];
        g_i        = col[15:8];
        b_i        = col[7:0];
        stipple_en = stip;
        pattern    = pat;
        cmd_valid  = 1'b1;
        @(negedge clk);
        cmd_valid  = 1'b0;
        x1         = 10'($urandom);
        y1         = 9'($urandom);
        x2         = 10'($urandom);
        y2         = 9'($urandom);
        r_i        = 8'($urandom);
        g_i        = 8'($urandom);
        b_i        = 8'($urandom);
        stipple_en = 1'($urandom);
        pattern    = 16'($urandom);
    endtask

    // mode 0: sink always ready; 1: random ready; 2: ready low on cycles 1..3
    task automatic run_line(input int ax1, input int ay1, input int ax2, input int ay2,
                            input bit stip, input logic [15:0] pat, input int mode);
        int          n_total, got, cyc;
        bit          done_seen, stalled;
        logic [63:0] prev;
        logic [23:0] col;
        build_model(ax1, ay1, ax2, ay2, stip, pat, n_total);
        issue(ax1, ay1, ax2, ay2, stip, pat, col);
        got       = 0;
        cyc       = 0;
        done_seen = 1'b0;
        stalled   = 1'b0;
        prev      = '0;
        while (!done_seen && cyc < 4000) begin
            case (mode)
                0:       px_ready = 1'b1;
                1:       px_ready = 1'($urandom_range(0, 1));
                default: px_ready = !(cyc >= 1 && cyc <= 3);
            endcase
            if (done) begin
                done_seen = 1'b1;
                check("cmd_ready_in_done", 64'(cmd_ready), 64'(0));
                if (mode == 0) check("done_latency", 64'(cyc), 64'(n_total));
            end else begin
                if (stalled) begin
                    check("hold_xy", 64'({X, Y}), prev);
                    check("hold_valid", 64'(px_valid), 64'(1));
                    check("hold_colour", 64'({r_o, g_o, b_o}), 64'(col));
                end
                if (cyc == 0) check("busy_draw", 64'(busy), 64'(1));
                if (px_valid && px_ready) begin
                    if (got < exp_x.size())
                        check("pixel", 64'({X, Y}), 64'((exp_x[got] << 9) | exp_y[got]));
                    else
                        check("extra_pixel", 64'(1), 64'(0));
                    check("colour", 64'({r_o, g_o, b_o}), 64'(col));
                    got++;
                end
                stalled = px_valid && !px_ready;
                prev    = 64'({X, Y});
            end
            @(negedge clk);
            cyc++;
        end
        if (!done_seen) check("done_timeout", 64'(0), 64'(1));
        check("pixel_count", 64'(got), 64'(exp_x.size()));
        check("done_one_cycle", 64'(done), 64'(0));
        check("cmd_ready_after", 64'(cmd_ready), 64'(1));
        px_ready = 1'b0;
    endtask

    task automatic run_abort();
        logic [23:0] col;
        int          got;
        bit          saw_done;
        issue(0, 0, 9, 0, 1'b0, 16'hFFFF, col);
        got = 0;
        for (int c = 0; c < 3; c++) begin
            px_ready = 1'b1;
            abort    = (c == 2);
            if (c == 2) check("abort_px_x", 64'(X), 64'(2));
            if (px_valid && px_ready) got++;
            @(negedge clk);
        end
        abort = 1'b0;
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_px_valid", 64'(px_valid), 64'(0));
        check("abort_cmd_ready", 64'(cmd_ready), 64'(1));
        check("abort_delivered", 64'(got), 64'(3));
        saw_done = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (done) saw_done = 1'b1;
            @(negedge clk);
        end
        check("abort_no_done", 64'(saw_done), 64'(0));
        px_ready = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_px_valid"}, 64'(px_valid), 64'(0));
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_done"}, 64'(done), 64'(0));
        check({tag, "_xy"}, 64'({X, Y}), 64'(0));
        check({tag, "_colour"}, 64'({r_o, g_o, b_o}), 64'(0));
    endtask

    task automatic run_reset_midline();
        logic [23:0] col;
        issue(0, 0, 20, 5, 1'b0, 16'hFFFF, col);
        px_ready = 1'b1;
        repeat (4) @(negedge clk);
        n_rst = 1'b0;
        @(negedge clk);
        check_reset_state("midrst");
        n_rst = 1'b1;
        @(negedge clk);
        check("midrst_cmd_ready", 64'(cmd_ready), 64'(1));
        check("midrst_no_done", 64'(done), 64'(0));
        px_ready = 1'b0;
    endtask

    initial begin
        int          ax1, ay1, ax2, ay2;
        logic [15:0] pat;
        n_rst      = 1'b0;
        cmd_valid  = 1'b0;
        x1         = '0;
        y1         = '0;
        x2         = '0;
        y2         = '0;
        r_i        = '0;
        g_i        = '0;
        b_i        = '0;
        stipple_en = 1'b0;
        pattern    = '0;
        abort      = 1'b0;
        px_ready   = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_state("reset");
        check("reset_cmd_ready", 64'(cmd_ready), 64'(1));
        n_rst = 1'b1;
        @(negedge clk);

        run_line(0, 0, 4, 0, 1'b0, 16'hFFFF, 0);
        run_line(0, 0, 4, 2, 1'b0, 16'hFFFF, 0);
        run_line(3, 3, 0, 0, 1'b0, 16'hFFFF, 0);
        run_line(5, 5, 5, 5, 1'b0, 16'hFFFF, 0);
        run_line(0, 0, 7, 0, 1'b0, 16'hFFFF, 2);
        run_line(0, 0, 7, 0, 1'b1, 16'h5555, 0);
        run_line(0, 0, 40, 3, 1'b1, 16'h0F35, 1);
        run_line(1023, 0, 0, 511, 1'b0, 16'hFFFF, 0);
        run_abort();
        run_reset_midline();

        for (int i = 0; i < 20; i++) begin
            if (i < 4) begin
                ax1 = $urandom_range(0, 1023);
                ax2 = $urandom_range(0, 1023);
                ay1 = $urandom_range(0, 511);
                ay2 = $urandom_range(0, 511);
            end else begin
                ax1 = $urandom_range(0, 40);
                ax2 = $urandom_range(0, 40);
                ay1 = $urandom_range(0, 40);
                ay2 = $urandom_range(0, 40);
            end
            pat = 16'($urandom);
            run_line(ax1, ay1, ax2, ay2, 1'($urandom), pat, (i % 3 == 0) ? 0 : 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
